// File: rtl/mips_pkg.sv
// Shared widths and FSM state encoding for the MIPS register-dump block.
package mips_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    CAPTURE,
    SEND,
    FINISH
  } dump_state_e;

endpackage

// File: rtl/mips_reg_dump_if.sv
// Register-file read port plus valid/ready dump stream. The master side is the dumper.
interface mips_reg_dump_if
  import mips_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);

  logic [ADDR_W-1:0] read_reg_addr;
  logic [DATA_W-1:0] read_reg_data;
  logic              dump_valid;
  logic              dump_ready;
  logic [ADDR_W-1:0] dump_addr;
  logic [DATA_W-1:0] dump_data;

  modport master (
    output read_reg_addr,
    input  read_reg_data,
    output dump_valid,
    input  dump_ready,
    output dump_addr,
    output dump_data
  );

  modport slave (
    input  read_reg_addr,
    output read_reg_data,
    input  dump_valid,
    output dump_ready,
    input  dump_addr,
    input  dump_data
  );

endinterface

// File: rtl/mips_reg_addr_seq.sv
// Address-range walker: holds cur/end, steps cur with power-of-two wrap, flags the last address.
module mips_reg_addr_seq
  import mips_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_first,
  input  logic [ADDR_W-1:0] i_last,
  input  logic              i_advance,
  output logic [ADDR_W-1:0] o_cur,
  output logic [ADDR_W-1:0] o_cur_inc,
  output logic              o_is_last
);

  logic [ADDR_W-1:0] r_cur;
  logic [ADDR_W-1:0] r_end;

  // NOTE: every flop is cleared by the async reset so an aborted dump leaves no stale range behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cur <= '0;
      r_end <= '0;
    end else if (i_load) begin
      r_cur <= i_first;
      r_end <= i_last;
    end else if (i_advance) begin
      r_cur <= o_cur_inc;
    end
  end

  assign o_cur     = r_cur;
  assign o_cur_inc = r_cur + 1'b1;
  assign o_is_last = (r_cur == r_end);

endmodule

// File: rtl/mips_reg_dump.sv
// Walks a wrapping register range, reading each register and streaming {addr, data} words out.
// Optional running checksum of accepted words: define MIPS_REG_DUMP_CHECKSUM_EN.
module mips_reg_dump
  import mips_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_addr,
  input  logic [ADDR_W-1:0] last_addr,
  mips_reg_dump_if.master   bus,
  output logic              busy,
  output logic              done
`ifdef MIPS_REG_DUMP_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum
`endif
);

  dump_state_e       r_state;
  dump_state_e       w_next_state;
  logic              w_load;
  logic              w_accept;
  logic              w_is_last;
  logic [ADDR_W-1:0] w_cur;
  logic [ADDR_W-1:0] w_cur_inc;
  logic [ADDR_W-1:0] r_read_addr;
  logic [ADDR_W-1:0] r_dump_addr;
  logic [DATA_W-1:0] r_dump_data;

  assign w_load   = (r_state == IDLE) && start;
  assign w_accept = (r_state == SEND) && bus.dump_ready;

  mips_reg_addr_seq #(.ADDR_W(ADDR_W)) u_addr_seq (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_load),
    .i_first   (first_addr),
    .i_last    (last_addr),
    .i_advance (w_accept && !w_is_last),
    .o_cur     (w_cur),
    .o_cur_inc (w_cur_inc),
    .o_is_last (w_is_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  // NOTE: next state defaults to the current one before the case, so no path can infer a latch.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (start) w_next_state = ISSUE;
      ISSUE:   w_next_state = CAPTURE;
      CAPTURE: w_next_state = SEND;
      SEND:    if (bus.dump_ready) w_next_state = w_is_last ? FINISH : ISSUE;
      FINISH:  w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // The read address is loaded on the way into ISSUE, so it shows cur there and holds elsewhere.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_read_addr <= '0;
      r_dump_addr <= '0;
      r_dump_data <= '0;
    end else begin
      if (w_load)
        r_read_addr <= first_addr;
      else if (w_accept && !w_is_last)
        r_read_addr <= w_cur_inc;
      if (r_state == CAPTURE) begin
        r_dump_data <= bus.read_reg_data;
        r_dump_addr <= w_cur;
      end
    end
  end

  assign bus.read_reg_addr = r_read_addr;
  assign bus.dump_addr     = r_dump_addr;
  assign bus.dump_data     = r_dump_data;
  assign bus.dump_valid    = (r_state == SEND);
  assign busy              = (r_state != IDLE);
  assign done              = (r_state == FINISH);

`ifdef MIPS_REG_DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] r_checksum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           r_checksum <= '0;
    else if (w_load)   r_checksum <= '0;
    else if (w_accept) r_checksum <= r_checksum + r_dump_data;
  end

  assign checksum = r_checksum;
`endif

endmodule

// File: tb/tb_mips_reg_dump.sv
// Directed bench for mips_reg_dump: vector table of dump ranges plus hand-written busy/reset sequences.
module tb_mips_reg_dump;

  typedef struct {
    logic [4:0] first;
    logic [4:0] last;
    int         n_words;
    bit         rnd_ready;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [4:0]  first_addr;
  logic [4:0]  last_addr;
  logic        busy;
  logic        done;
`ifdef MIPS_REG_DUMP_CHECKSUM_EN
  logic [31:0] checksum;
  logic [31:0] done_checksum;
`endif

  logic [31:0] rf [32];
  int          n_checks = 0;
  int          n_errors = 0;
  vec_t        vecs [7];

  mips_reg_dump_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  mips_reg_dump #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .first_addr (first_addr),
    .last_addr  (last_addr),
    .bus        (bus),
    .busy       (busy),
    .done       (done)
`ifdef MIPS_REG_DUMP_CHECKSUM_EN
    ,
    .checksum   (checksum)
`endif
  );

  always #5 clk = ~clk;

  // Synchronous-read register file model: data appears one clock after the address.
  always @(posedge clk) bus.read_reg_data <= rf[bus.read_reg_addr];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 20 && !bus.dump_valid; i++) @(negedge clk);
    check("wait_valid", bus.dump_valid, 1'b1);
  endtask

  // Called at a negedge; issues start and follows the dump until done or a cycle budget expires.
  task automatic run_dump(input logic [4:0] f, input logic [4:0] l, input int n_exp, input bit rnd);
    int         got      = 0;
    int         cyc      = 0;
    int         done_cyc = -1;
    bit         held     = 1'b0;
    logic [4:0] exp_a    = f;
    logic [4:0] h_a      = '0;
    logic [31:0] h_d     = '0;
    start = 1'b1; first_addr = f; last_addr = l;
    @(negedge clk);
    start = 1'b0; cyc = 1;
    check("busy_after_start", busy, 1'b1);
    while (done_cyc < 0 && cyc < 3000) begin
      bus.dump_ready = rnd ? ($urandom_range(0, 1) != 0) : 1'b1;
      if (held) check("valid_held", bus.dump_valid, 1'b1);
      if (bus.dump_valid) begin
        if (held) begin
          check("hold_addr", bus.dump_addr, h_a);
          check("hold_data", bus.dump_data, h_d);
        end
        if (bus.dump_ready) begin
          check("word_addr", bus.dump_addr, exp_a);
          check("word_data", bus.dump_data, rf[exp_a]);
          got++;
          exp_a = exp_a + 5'd1;
          held  = 1'b0;
        end else begin
          held = 1'b1;
          h_a  = bus.dump_addr;
          h_d  = bus.dump_data;
        end
      end else begin
        held = 1'b0;
      end
      if (done) begin
        done_cyc = cyc;
`ifdef MIPS_REG_DUMP_CHECKSUM_EN
        done_checksum = checksum;
`endif
      end
      @(negedge clk);
      cyc++;
    end
    check("done_seen", (done_cyc >= 0), 1'b1);
    check("word_count", got, n_exp);
    if (!rnd) check("done_cycle", done_cyc, 3 * n_exp + 1);
    check("done_one_cycle", done, 1'b0);
    check("idle_after_done", busy, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = i * 32'h1111_1111;
    vecs[0] = '{5'd0,  5'd31, 32, 1'b0};
    vecs[1] = '{5'd30, 5'd1,  4,  1'b0};
    vecs[2] = '{5'd5,  5'd5,  1,  1'b0};
    vecs[3] = '{5'd0,  5'd0,  1,  1'b0};
    vecs[4] = '{5'd31, 5'd0,  2,  1'b0};
    vecs[5] = '{5'd7,  5'd20, 14, 1'b1};
    vecs[6] = '{5'd25, 5'd24, 32, 1'b1};

    rst = 1'b1; start = 1'b0; first_addr = '0; last_addr = '0; bus.dump_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_valid", bus.dump_valid, 1'b0);
    check("rst_dump_addr", bus.dump_addr, 5'd0);
    check("rst_dump_data", bus.dump_data, 32'd0);
    check("rst_read_addr", bus.read_reg_addr, 5'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 7; v++) begin
      run_dump(vecs[v].first, vecs[v].last, vecs[v].n_words, vecs[v].rnd_ready);
      @(negedge clk);
    end

    // start while busy is ignored, then reset aborts mid-SEND.
    bus.dump_ready = 1'b0;
    start = 1'b1; first_addr = 5'd0; last_addr = 5'd31;
    @(negedge clk);
    start = 1'b0;
    wait_valid();
    check("held_read_addr", bus.read_reg_addr, 5'd0);
    start = 1'b1; first_addr = 5'd10; last_addr = 5'd10;
    @(negedge clk);
    start = 1'b0;
    check("ignore_start_addr", bus.dump_addr, 5'd0);
    check("ignore_start_valid", bus.dump_valid, 1'b1);
    bus.dump_ready = 1'b1;
    @(negedge clk);
    bus.dump_ready = 1'b0;
    wait_valid();
    check("ignore_start_next_addr", bus.dump_addr, 5'd1);
    check("ignore_start_next_data", bus.dump_data, rf[1]);
    rst = 1'b1;
    #1;
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_valid", bus.dump_valid, 1'b0);
    check("abort_dump_addr", bus.dump_addr, 5'd0);
    check("abort_dump_data", bus.dump_data, 32'd0);
    check("abort_read_addr", bus.read_reg_addr, 5'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("abort_no_done", done, 1'b0);
    end
    run_dump(5'd3, 5'd4, 2, 1'b0);

`ifdef MIPS_REG_DUMP_CHECKSUM_EN
    rf[1] = 32'h0000_0001;
    rf[2] = 32'h0000_0002;
    rf[3] = 32'hFFFF_FFFF;
    @(negedge clk);
    run_dump(5'd1, 5'd3, 3, 1'b0);
    check("checksum_at_done", done_checksum, 32'h0000_0002);
    check("checksum_stable", checksum, 32'h0000_0002);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
